// File: rtl/avalon_mem_arbiter_if.sv
// Avalon-MM port bundle used on both sides of the memory arbiter.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives waitrequest/readdata
//   slave modport  : the mirror image, used by whoever serves the transfer
interface avalon_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM RAM slave between the CPU (m0) and the program
// loader / debug master (m1). One whole transfer is granted at a time,
// round-robin or fixed-priority, and the grant is held across slave stalls.
//   clk, reset : system clock, synchronous active-high reset
//   m0, m1     : requesting masters (arbiter acts as their slave)
//   s          : the shared RAM (arbiter acts as its master)
//   grant_id   : owner of the current grant, or of the last completed one
//   busy       : a grant is active
//
// state | meaning
// IDLE  | no grant; bubble cycle between transfers
// G0    | m0 owns the slave until s.waitrequest drops
// G1    | m1 owns the slave until s.waitrequest drops
module avalon_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    avalon_mem_arbiter_if.slave  m0,
    avalon_mem_arbiter_if.slave  m1,
    avalon_mem_arbiter_if.master s,
    output logic                 grant_id,
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    // Reported owner while idle. Tracks last_grant except out of reset, where
    // arbitration starts from 1 (so m0 wins the first tie) but the reported
    // owner starts from 0.
    logic   shown_grant, shown_grant_nxt;

    logic m0_req, m1_req;

    assign m0_req = m0.read | m0.write;
    assign m1_req = m1.read | m1.write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            shown_grant <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            shown_grant <= shown_grant_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        shown_grant_nxt = shown_grant;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt = ((FIXED_PRIO != 0) || last_grant) ? G0 : G1;
                end else if (m0_req) begin
                    state_nxt = G0;
                end else if (m1_req) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                // A dropped request aborts the grant without crediting it.
                if (!m0_req) begin
                    state_nxt = IDLE;
                end else if (!s.waitrequest) begin
                    state_nxt       = IDLE;
                    last_grant_nxt  = 1'b0;
                    shown_grant_nxt = 1'b0;
                end
            end
            G1: begin
                if (!m1_req) begin
                    state_nxt = IDLE;
                end else if (!s.waitrequest) begin
                    state_nxt       = IDLE;
                    last_grant_nxt  = 1'b1;
                    shown_grant_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s.address      = {ADDR_W{1'b0}};
        s.read         = 1'b0;
        s.write        = 1'b0;
        s.writedata    = {DATA_W{1'b0}};
        s.byteenable   = {(DATA_W/8){1'b0}};
        m0.waitrequest = 1'b1;
        m0.readdata    = {DATA_W{1'b0}};
        m1.waitrequest = 1'b1;
        m1.readdata    = {DATA_W{1'b0}};
        grant_id       = shown_grant;
        busy           = 1'b0;
        case (state)
            G0: begin
                s.address      = m0.address;
                s.write        = m0.write;
                s.read         = m0.read & ~m0.write;
                s.writedata    = m0.writedata;
                s.byteenable   = m0.byteenable;
                m0.waitrequest = s.waitrequest;
                m0.readdata    = s.readdata;
                grant_id       = 1'b0;
                busy           = 1'b1;
            end
            G1: begin
                s.address      = m1.address;
                s.write        = m1.write;
                s.read         = m1.read & ~m1.write;
                s.writedata    = m1.writedata;
                s.byteenable   = m1.byteenable;
                m1.waitrequest = s.waitrequest;
                m1.readdata    = s.readdata;
                grant_id       = 1'b1;
                busy           = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter: a per-cycle vector table on a
// round-robin instance backed by a small RAM model, then hand sequences for
// reset mid-transfer and a fixed-priority instance.
module tb_avalon_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_reset, b_reset;
    logic a_gid, a_busy, b_gid, b_busy;

    avalon_mem_arbiter_if a_m0 ();
    avalon_mem_arbiter_if a_m1 ();
    avalon_mem_arbiter_if a_s ();
    avalon_mem_arbiter_if b_m0 ();
    avalon_mem_arbiter_if b_m1 ();
    avalon_mem_arbiter_if b_s ();

    avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .reset(a_reset), .m0(a_m0), .m1(a_m1), .s(a_s),
        .grant_id(a_gid), .busy(a_busy)
    );

    avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(b_reset), .m0(b_m0), .m1(b_m1), .s(b_s),
        .grant_id(b_gid), .busy(b_busy)
    );

    // RAM model behind the round-robin instance (word addressed by address[7:2]).
    logic [31:0] ram [0:63];
    assign a_s.readdata = ram[a_s.address[7:2]];
    assign b_s.readdata = 32'h0;

    always @(posedge clk) begin
        if (a_reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
            ram[1] <= 32'hAAAA0004;
            ram[2] <= 32'hBBBB0008;
            ram[3] <= 32'h10430002;
        end else if (a_s.write && !a_s.waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (a_s.byteenable[b]) ram[a_s.address[7:2]][8*b +: 8] <= a_s.writedata[8*b +: 8];
        end
    end

    typedef struct {
        logic        rst, chk;
        logic        m0_rd, m0_wr;
        logic [31:0] m0_a, m0_wd;
        logic        m1_rd, m1_wr;
        logic [31:0] m1_a, m1_wd;
        logic        sw;
        logic        busy, gid, s_rd, s_wr;
        logic [31:0] s_a, s_wd;
        logic [3:0]  s_be;
        logic        w0, w1;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, chk, m0_rd, m0_wr, input logic [31:0] m0_a, m0_wd,
                       input logic m1_rd, m1_wr, input logic [31:0] m1_a, m1_wd, input logic sw,
                       input logic busy, gid, s_rd, s_wr, input logic [31:0] s_a, s_wd,
                       input logic [3:0] s_be, input logic w0, w1, input logic [31:0] rd0, rd1);
        vec_t v;
        v.rst = rst; v.chk = chk; v.m0_rd = m0_rd; v.m0_wr = m0_wr; v.m0_a = m0_a; v.m0_wd = m0_wd;
        v.m1_rd = m1_rd; v.m1_wr = m1_wr; v.m1_a = m1_a; v.m1_wd = m1_wd; v.sw = sw;
        v.busy = busy; v.gid = gid; v.s_rd = s_rd; v.s_wr = s_wr; v.s_a = s_a; v.s_wd = s_wd;
        v.s_be = s_be; v.w0 = w0; v.w1 = w1; v.rd0 = rd0; v.rd1 = rd1;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_m0.read = 0; a_m0.write = 0; a_m0.address = 0; a_m0.writedata = 0; a_m0.byteenable = 4'h3;
        a_m1.read = 0; a_m1.write = 0; a_m1.address = 0; a_m1.writedata = 0; a_m1.byteenable = 4'hF;
        a_s.waitrequest = 0;
        b_m0.read = 0; b_m0.write = 0; b_m0.address = 0; b_m0.writedata = 0; b_m0.byteenable = 4'hF;
        b_m1.read = 0; b_m1.write = 0; b_m1.address = 0; b_m1.writedata = 0; b_m1.byteenable = 4'hF;
        b_s.waitrequest = 0;

        //  rst chk m0rd m0wr m0a  m0wd          m1rd m1wr m1a  m1wd          sw | busy gid srd swr sa   swd           be   w0 w1 rd0           rd1
        add(1, 0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(1, 1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        // simultaneous m0 read / m1 write: m0 first, bubble, then m1
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 1, 32'h08, 32'h24030100, 0,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 1, 32'h08, 32'h24030100, 0,  1, 0, 1, 0, 32'h04, 32'h0,        4'h3, 0, 1, 32'hAAAA0004, 32'h0);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 1, 32'h08, 32'h24030100, 0,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 1, 32'h08, 32'h24030100, 0,  1, 1, 0, 1, 32'h08, 32'h24030100, 4'hF, 1, 0, 32'h0,        32'hBBBB0008);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 1, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        // single CPU read at 0x0C
        add(0, 1, 1, 0, 32'h0C, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 1, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(0, 1, 1, 0, 32'h0C, 32'h0,        0, 0, 32'h00, 32'h0,        0,  1, 0, 1, 0, 32'h0C, 32'h0,        4'h3, 0, 1, 32'h10430002, 32'h0);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        // m1 write stalled 3 cycles while m0 waits; round-robin picks m1
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 1, 32'h10, 32'h55AA33CC, 1,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 1, 32'h10, 32'h55AA33CC, 1,  1, 1, 0, 1, 32'h10, 32'h55AA33CC, 4'hF, 1, 1, 32'h0,        32'h0);
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 1, 32'h10, 32'h55AA33CC, 1,  1, 1, 0, 1, 32'h10, 32'h55AA33CC, 4'hF, 1, 1, 32'h0,        32'h0);
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 1, 32'h10, 32'h55AA33CC, 1,  1, 1, 0, 1, 32'h10, 32'h55AA33CC, 4'hF, 1, 1, 32'h0,        32'h0);
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 1, 32'h10, 32'h55AA33CC, 0,  1, 1, 0, 1, 32'h10, 32'h55AA33CC, 4'hF, 1, 0, 32'h0,        32'h0);
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 1, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(0, 1, 1, 0, 32'h04, 32'h0,        0, 0, 32'h00, 32'h0,        0,  1, 0, 1, 0, 32'h04, 32'h0,        4'h3, 0, 1, 32'hAAAA0004, 32'h0);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        // m0 read+write (treated as write), then drops the request mid-grant
        add(0, 1, 1, 1, 32'h14, 32'h11112222, 0, 0, 32'h00, 32'h0,        1,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(0, 1, 1, 1, 32'h14, 32'h11112222, 0, 0, 32'h00, 32'h0,        1,  1, 0, 0, 1, 32'h14, 32'h11112222, 4'h3, 1, 1, 32'h0,        32'h0);
        add(0, 1, 0, 0, 32'h14, 32'h11112222, 0, 1, 32'h18, 32'h77,       1,  1, 0, 0, 0, 32'h14, 32'h11112222, 4'h3, 1, 1, 32'h0,        32'h0);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 1, 32'h18, 32'h77,       0,  0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 1, 32'h18, 32'h77,       0,  1, 1, 0, 1, 32'h18, 32'h77,       4'hF, 1, 0, 32'h0,        32'h0);
        add(0, 1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0,  0, 1, 0, 0, 32'h00, 32'h0,        4'h0, 1, 1, 32'h0,        32'h0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            a_reset         = vecs[i].rst;
            a_m0.read       = vecs[i].m0_rd;
            a_m0.write      = vecs[i].m0_wr;
            a_m0.address    = vecs[i].m0_a;
            a_m0.writedata  = vecs[i].m0_wd;
            a_m1.read       = vecs[i].m1_rd;
            a_m1.write      = vecs[i].m1_wr;
            a_m1.address    = vecs[i].m1_a;
            a_m1.writedata  = vecs[i].m1_wd;
            a_s.waitrequest = vecs[i].sw;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("row%0d busy", i),     {31'h0, a_busy},          {31'h0, vecs[i].busy});
                check($sformatf("row%0d grant_id", i), {31'h0, a_gid},           {31'h0, vecs[i].gid});
                check($sformatf("row%0d s_read", i),   {31'h0, a_s.read},        {31'h0, vecs[i].s_rd});
                check($sformatf("row%0d s_write", i),  {31'h0, a_s.write},       {31'h0, vecs[i].s_wr});
                check($sformatf("row%0d s_address", i), a_s.address,             vecs[i].s_a);
                check($sformatf("row%0d s_writedata", i), a_s.writedata,         vecs[i].s_wd);
                check($sformatf("row%0d s_byteenable", i), {28'h0, a_s.byteenable}, {28'h0, vecs[i].s_be});
                check($sformatf("row%0d m0_wait", i),  {31'h0, a_m0.waitrequest}, {31'h0, vecs[i].w0});
                check($sformatf("row%0d m1_wait", i),  {31'h0, a_m1.waitrequest}, {31'h0, vecs[i].w1});
                check($sformatf("row%0d m0_rdata", i), a_m0.readdata,            vecs[i].rd0);
                check($sformatf("row%0d m1_rdata", i), a_m1.readdata,            vecs[i].rd1);
            end
            next_cycle();
        end

        check("ram 0x08", ram[2], 32'h24030100);
        check("ram 0x10", ram[4], 32'h55AA33CC);
        check("ram 0x14 aborted", ram[5], 32'h0);
        check("ram 0x18", ram[6], 32'h77);

        // Reset while G0 is stalled; last_grant is 1 here from the m1 transfer.
        a_m0.read = 1; a_m0.address = 32'h0C; a_s.waitrequest = 1;
        #1;
        check("rst_seq idle busy", {31'h0, a_busy}, 32'h0);
        next_cycle();
        #1;
        check("rst_seq g0 busy", {31'h0, a_busy}, 32'h1);
        check("rst_seq g0 s_read", {31'h0, a_s.read}, 32'h1);
        check("rst_seq g0 m0_wait", {31'h0, a_m0.waitrequest}, 32'h1);
        a_reset = 1;
        next_cycle();
        a_reset = 0;
        a_m1.write = 1; a_m1.address = 32'h1C; a_m1.writedata = 32'h99; a_s.waitrequest = 0;
        #1;
        check("rst_seq after busy", {31'h0, a_busy}, 32'h0);
        check("rst_seq after s_read", {31'h0, a_s.read}, 32'h0);
        check("rst_seq after m0_wait", {31'h0, a_m0.waitrequest}, 32'h1);
        check("rst_seq after grant_id", {31'h0, a_gid}, 32'h0);
        next_cycle();
        #1;
        check("rst_seq tie busy", {31'h0, a_busy}, 32'h1);
        check("rst_seq tie grant_id", {31'h0, a_gid}, 32'h0);
        check("rst_seq tie s_read", {31'h0, a_s.read}, 32'h1);
        a_m0.read = 0; a_m1.write = 0;
        next_cycle();

        // Fixed priority: m0 keeps winning while both request back-to-back.
        next_cycle();
        b_reset = 0;
        b_m0.read = 1; b_m0.address = 32'h20;
        b_m1.read = 1; b_m1.address = 32'h24;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("fp c%0d busy", c), {31'h0, b_busy}, {31'h0, (c % 2) == 1});
            check($sformatf("fp c%0d grant_id", c), {31'h0, b_gid}, 32'h0);
            check($sformatf("fp c%0d m1_wait", c), {31'h0, b_m1.waitrequest}, 32'h1);
            next_cycle();
        end
        b_m0.read = 0;
        #1;
        check("fp release busy", {31'h0, b_busy}, 32'h0);
        next_cycle();
        #1;
        check("fp m1 busy", {31'h0, b_busy}, 32'h1);
        check("fp m1 grant_id", {31'h0, b_gid}, 32'h1);
        check("fp m1 wait", {31'h0, b_m1.waitrequest}, 32'h0);
        check("fp m1 s_address", b_s.address, 32'h24);
        b_m1.read = 0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
